// File: rtl/led_blinker.sv
// Turns a one-cycle start request into count LED blinks of ON_CYCLES lit / OFF_CYCLES dark,
// with busy while running and a one-cycle done pulse on normal completion.
module led_blinker #(
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned OFF_CYCLES = 8,
    parameter int unsigned TIME_W     = 8,
    parameter int unsigned BLINK_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLINK_W-1:0] count,
    input  logic               stop,
    output logic               led,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [TIME_W-1:0]  ON_LOAD  = TIME_W'(ON_CYCLES - 1);
    localparam logic [TIME_W-1:0]  OFF_LOAD = TIME_W'(OFF_CYCLES - 1);
    localparam logic [BLINK_W-1:0] ONE      = BLINK_W'(1);

    state_t             state, state_d;
    logic [TIME_W-1:0]  timer, timer_d;
    logic [BLINK_W-1:0] remaining, remaining_d;
    logic               led_d, busy_d, done_d;

    // State, counters and outputs all update together; outputs are derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            remaining <= remaining_d;
            led       <= led_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        remaining_d = remaining;

        case (state)
            IDLE: begin
                if (start && !stop && (count != '0)) begin
                    state_d     = ON;
                    timer_d     = ON_LOAD;
                    remaining_d = count;
                end
            end
            ON: begin
                if (stop) begin
                    state_d     = IDLE;
                    timer_d     = '0;
                    remaining_d = '0;
                end else if (timer == '0) begin
                    state_d = OFF;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer - TIME_W'(1);
                end
            end
            OFF: begin
                if (stop) begin
                    state_d     = IDLE;
                    timer_d     = '0;
                    remaining_d = '0;
                end else if (timer == '0) begin
                    // Blink finished: either start the next one or end the sequence.
                    remaining_d = remaining - ONE;
                    if (remaining == ONE) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        state_d = ON;
                        timer_d = ON_LOAD;
                    end
                end else begin
                    timer_d = timer - TIME_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                timer_d     = '0;
                remaining_d = '0;
            end
        endcase

        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
        // done marks the last dark cycle of the final blink.
        done_d = (state_d == OFF) && (timer_d == '0) && (remaining_d == ONE);
    end

endmodule

// File: doc/led_blinker.md
# led_blinker

Output-side indicator driver: turns a one-cycle request into a visible, timed LED blink sequence. It is the counterpart of the input conditioning path. Debounced single-cycle button events come in on `start`, and the block drives a board LED with `count` blinks of programmable on/off length. It reports `busy` while running and a one-cycle `done` at completion. It sits between control logic and the board LED pins.

## Interface
- `ON_CYCLES`, default 8: clock cycles LED is lit per blink; must be ≥1 and < 2^TIME_W.
- `OFF_CYCLES`, default 8: clock cycles LED is dark after each blink; must be ≥1 and < 2^TIME_W.
- `TIME_W`, default 8: width of the phase timer.
- `BLINK_W`, default 3: width of `count`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high. Forces the IDLE state and clears all outputs immediately.
- `start` in 1: request strobe; sampled on rising edge.
- `count` in BLINK_W: number of blinks; sampled only with an accepted `start`.
- `stop` in 1: synchronous abort.
- `led` out 1: LED drive, active-high.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ON, OFF.
- Reset values: state=IDLE, `led`=0, `busy`=0, `done`=0, timer=0, remaining-blink counter=0.
- IDLE behaviour:
  - `start`=1, `stop`=0, `count`≠0: latch `count` into remaining, load timer, go to ON.
  - `count`=0: `start` is ignored; the block stays IDLE and `done` is not pulsed.
- ON behaviour:
  - `led`=1 for exactly ON_CYCLES cycles, then go to OFF.
- OFF behaviour:
  - `led`=0 for exactly OFF_CYCLES cycles.
  - On the final OFF cycle, decrement remaining.
  - If remaining was 1, go to IDLE; otherwise go to ON.
- `busy`=1 in ON and OFF, 0 in IDLE. Outputs are registered, with no combinational path from inputs.
- `done`=1 only during the final OFF cycle of the last blink, when the sequence completes normally. It is never asserted on abort.
- `start` while `busy`=1 is ignored; no queuing and no retrigger.
- `stop`=1 in ON or OFF: at the next edge go to IDLE with `led`=0 and `busy`=0, and no `done`.
- `start` and `stop` high together in IDLE: `stop` wins and nothing starts.
- `reset` asserted mid-sequence: outputs clear asynchronously. After release the block is in IDLE, and the first accepted `start` behaves as from power-up.
- Timer counts down from ON_CYCLES-1 or OFF_CYCLES-1 to 0. Phase changes when the timer reaches 0, with no wrap-around.
- Remaining counter is BLINK_W bits. The maximum count, 2^BLINK_W−1, is legal.

## Timing
- Latency:
  - `start` accepted at edge E.
  - `led` and `busy` rise immediately after E (first ON cycle is the one following E).
- Total `busy` high time = count×(ON_CYCLES+OFF_CYCLES) cycles.
- `done` is high during the last of those cycles. `busy` falls at the same edge `done` falls.
- Back-to-back operation: a `start` presented in the cycle right after `busy` falls is accepted. The idle gap is therefore at least 1 cycle.
- `stop` latency: 1 edge.
- `reset` latency: asynchronous, with no clock needed.

## Test plan
Parameters for all scenarios: ON_CYCLES=3, OFF_CYCLES=2, BLINK_W=3.
- **Reset:** assert `reset` mid-clock with no edge → `led`=`busy`=`done`=0 immediately. Release, then hold `start`=0 for 10 cycles → all outputs stay 0.
- **Single blink:** `start`=1, `count`=1 for one cycle → `led` pattern 1,1,1,0,0. `busy` high for 5 cycles. `done` high only in cycle 5. Then idle.
- **Max count:** `count`=7 → 7 repetitions of 1,1,1,0,0. `busy` high for 35 cycles. Exactly one `done` pulse, in cycle 35.
- **Ignored requests:**
  - `count`=0 with `start` → no activity and no `done`.
  - Second `start` with `count`=5 during a `count`=2 sequence → still exactly 10 busy cycles.
- **Abort:**
  - `stop` in the 2nd ON cycle of blink 2 of 3 → `led`=0 and `busy`=0 at the next edge; `done` never pulses.
  - `start`+`stop` together in IDLE → nothing starts.
- **Reset mid-sequence and back-to-back:**
  - `reset` during OFF → immediate clear. Then `start`, `count`=1 → normal 5-cycle sequence.
  - `start` in the first IDLE cycle after a completed sequence → accepted.
